fc_cfg_apb_arbiter: RTL and testbench

Shares the single FC configuration APB target port among NUM_REQ register-access requesters (AXI-side bridge, CHI-side bridge, TB config agent). It arbitrates round-robin, sequences APB SETUP/ACCESS phases and returns read data and response to the winning requester. A watchdog aborts transfers stalled by pready and reports an error. It sits between the requester bridges and the DUT config APB port in the FC top-level environment.

---
 rtl/fc_cfg_apb_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_fc_cfg_apb_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_cfg_apb_arbiter.sv
// rtl/fc_cfg_apb_arbiter.sv - round-robin arbiter sharing one APB config target among NUM_REQ requesters
//
// Purpose: grants one requester at a time (round-robin from the last owner),
// runs the APB SETUP/ACCESS handshake, returns read data/response to the
// owner with a one-cycle done pulse, and aborts ACCESS phases stalled by pready.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   req/req_write              per-requester request and direction
//   req_addr/req_wdata         packed per-requester payload (slot i at [i*W +: W])
//   done                       one-cycle completion pulse to the owner
//   rsp_rdata/rsp_err          response, valid while done!=0, held afterwards
//   psel/penable/pwrite        APB control
//   paddr/pwdata/prdata        APB address and data
//   pready/pslverr             APB completion and error
//   timeout_cnt                saturating count of watchdog aborts

module fc_cfg_apb_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr,
  output logic [7:0]                timeout_cnt
);

  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam int WD_W    = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;

  localparam logic [PTR_W-1:0] LAST_RST = PTR_W'(NUM_REQ - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TO_LAST);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic [PTR_W-1:0]    last_q, last_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic                psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic [7:0]          tmo_cnt_q, tmo_cnt_d;

  logic                gnt_valid;
  logic [PTR_W-1:0]    gnt_idx;

  // Scan from farthest to nearest after last_q so the nearest set bit wins.
  always_comb begin
    int j;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    j         = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(last_q) + k) % NUM_REQ;
      if (req[j]) begin
        gnt_valid = 1'b1;
        gnt_idx   = PTR_W'(j);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    wd_d        = wd_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    done_d      = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    tmo_cnt_d   = tmo_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          owner_d  = gnt_idx;
          pwrite_d = req_write[gnt_idx];
          paddr_d  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
          pwdata_d = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
          psel_d   = 1'b1;
          wd_d     = '0;
          state_d  = S_SETUP;
        end
      end

      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end

      S_ACCESS: begin
        // pready wins over a watchdog expiry in the same cycle.
        if (pready) begin
          rsp_rdata_d     = pwrite_q ? '0 : prdata;
          rsp_err_d       = pslverr;
          done_d[owner_q] = 1'b1;
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          last_d          = owner_q;
          state_d         = S_DONE;
        end else if ((TIMEOUT_CYC != 0) && (wd_q == WD_LAST)) begin
          rsp_rdata_d     = '0;
          rsp_err_d       = 1'b1;
          done_d[owner_q] = 1'b1;
          psel_d          = 1'b0;
          penable_d       = 1'b0;
          last_d          = owner_q;
          tmo_cnt_d       = (tmo_cnt_q == 8'hFF) ? tmo_cnt_q : tmo_cnt_q + 8'd1;
          state_d         = S_DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      // Dead cycle: the owner sees done and can drop req before the next scan.
      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d   = S_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      last_q      <= LAST_RST;
      wd_q        <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      done_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tmo_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      wd_q        <= wd_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      done_q      <= done_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      tmo_cnt_q   <= tmo_cnt_d;
    end
  end

  assign done        = done_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign timeout_cnt = tmo_cnt_q;

endmodule

// File: tb/tb_fc_cfg_apb_arbiter.sv
// tb/tb_fc_cfg_apb_arbiter.sv - scoreboard bench for fc_cfg_apb_arbiter
module tb_fc_cfg_apb_arbiter;

  localparam int NR  = 3;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     done;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata;
  logic [DW-1:0]     prdata;
  logic              pready;
  logic              pslverr;
  logic [7:0]        timeout_cnt;

  logic [AW-1:0]     r_addr  [NR];
  logic [DW-1:0]     r_wdata [NR];

  int                stall_n;
  logic              slv_err_en;
  logic [DW-1:0]     rd_key;
  int                acc_cnt;
  int                cyc = 0;
  int                exp_tmo;

  int                n_tests = 0;
  int                n_fail  = 0;

  typedef struct {
    logic [NR-1:0] done;
    logic [DW-1:0] rdata;
    logic          err;
    int            lat;
  } exp_t;

  exp_t sb_q[$];

  fc_cfg_apb_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .done(done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .psel(psel),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = r_addr[i];
      req_wdata[i*DW +: DW] = r_wdata[i];
    end
  end

  // APB target: inserts stall_n wait states in ACCESS, read data derived from address.
  always @(posedge clk or posedge rst) begin
    if (rst) acc_cnt <= 0;
    else if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end
  assign pready  = psel & penable & (acc_cnt >= stall_n);
  assign pslverr = pready & slv_err_en;
  assign prdata  = paddr ^ rd_key;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int who, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    logic to;
    to = (TMO != 0) && (stall_n >= TMO);
    r_addr[who]    = a;
    r_wdata[who]   = d;
    req_write[who] = wr;
    req[who]       = 1'b1;
    e.done         = '0;
    e.done[who]    = 1'b1;
    e.rdata        = (to || wr) ? '0 : (a ^ rd_key);
    e.err          = to ? 1'b1 : slv_err_en;
    e.lat          = to ? 2 + TMO : 3 + stall_n;
    sb_q.push_back(e);
  endtask

  task automatic await_done(output logic [NR-1:0] od, output logic [DW-1:0] ord,
                            output logic oe, output int lat);
    bit got;
    got = 1'b0; lat = 0; od = '0; ord = '0; oe = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      lat++;
      if (done != '0) begin
        got = 1'b1; od = done; ord = rsp_rdata; oe = rsp_err;
      end
    end
    if (!got) lat = -1;
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb_q.size() == 0) begin
      e.done = '1; e.rdata = '1; e.err = 1'bx; e.lat = -2;
    end else begin
      e = sb_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_write = '0;
    for (int i = 0; i < NR; i++) begin r_addr[i] = '0; r_wdata[i] = '0; end
    stall_n = 0; slv_err_en = 1'b0; rd_key = '0; exp_tmo = 0;
    tick(); tick();
    n_tests++; if ({psel, penable} !== 2'b00) begin n_fail++; $display("FAIL reset.psel_penable got %b want 00", {psel, penable}); end
    n_tests++; if (done !== '0) begin n_fail++; $display("FAIL reset.done got %b want 000", done); end
    n_tests++; if ({rsp_err, rsp_rdata} !== '0) begin n_fail++; $display("FAIL reset.rsp got %b/%h want 0/0", rsp_err, rsp_rdata); end
    n_tests++; if ({pwrite, paddr, pwdata, timeout_cnt} !== '0) begin n_fail++; $display("FAIL reset.apb_cnt got %b %h %h %0d want 0", pwrite, paddr, pwdata, timeout_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    exp_t e;
    rd_key = 32'h1111_0000;
    issue(0, 1'b1, 32'h100, 32'hDEADBEEF);
    tick();
    n_tests++; if ({psel, penable, pwrite} !== 3'b101) begin n_fail++; $display("FAIL single_write.c1_ctrl got %b want 101", {psel, penable, pwrite}); end
    n_tests++; if ({paddr, pwdata} !== {32'h100, 32'hDEADBEEF}) begin n_fail++; $display("FAIL single_write.c1_payload got %h %h want 100 deadbeef", paddr, pwdata); end
    tick();
    n_tests++; if ({psel, penable, done} !== {2'b11, 3'b000}) begin n_fail++; $display("FAIL single_write.c2 got %b want 11000", {psel, penable, done}); end
    tick();
    pop_exp(e);
    n_tests++; if (done !== e.done) begin n_fail++; $display("FAIL single_write.done got %b want %b", done, e.done); end
    n_tests++; if ({rsp_err, rsp_rdata} !== {e.err, e.rdata}) begin n_fail++; $display("FAIL single_write.rsp got %b/%h want %b/%h", rsp_err, rsp_rdata, e.err, e.rdata); end
    n_tests++; if ({psel, penable} !== 2'b00) begin n_fail++; $display("FAIL single_write.c3_idle got %b want 00", {psel, penable}); end
    req[0] = 1'b0;
    tick();
    n_tests++; if (done !== '0) begin n_fail++; $display("FAIL single_write.done_one_cycle got %b want 000", done); end
    tick(); tick();
    n_tests++; if (psel !== 1'b0) begin n_fail++; $display("FAIL single_write.no_regrant got %b want 0", psel); end
  endtask

  task automatic test_round_robin();
    exp_t e;
    logic [NR-1:0] od;
    logic [DW-1:0] ord;
    logic oe;
    int lat, prev;
    rst = 1'b1; tick(); rst = 1'b0; exp_tmo = 0;
    rd_key = 32'h0F0F_0000; stall_n = 0;
    issue(0, 1'b0, 32'h200, '0);
    issue(1, 1'b0, 32'h204, '0);
    issue(2, 1'b0, 32'h208, '0);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      await_done(od, ord, oe, lat);
      pop_exp(e);
      n_tests++; if (lat < 0) begin n_fail++; $display("FAIL round_robin.wait k=%0d got no done want done", k); break; end
      n_tests++; if (od !== e.done) begin n_fail++; $display("FAIL round_robin.order k=%0d got %b want %b", k, od, e.done); end
      n_tests++; if ({oe, ord} !== {e.err, e.rdata}) begin n_fail++; $display("FAIL round_robin.rsp k=%0d got %b/%h want %b/%h", k, oe, ord, e.err, e.rdata); end
      if (k > 0) begin
        n_tests++; if (cyc - prev !== 4) begin n_fail++; $display("FAIL round_robin.spacing k=%0d got %0d want 4", k, cyc - prev); end
      end
      prev = cyc;
      req = req & ~od;
      if (k == 2) issue(0, 1'b0, 32'h20C, '0);
    end
    req = '0;
    tick();
  endtask

  task automatic test_read_stall();
    exp_t e;
    bit stable;
    stall_n = 3;
    rd_key = 32'h5A5A_0001 ^ 32'h340;
    issue(1, 1'b0, 32'h340, 32'hFFFF_FFFF);
    stable = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (paddr !== 32'h340 || pwrite !== 1'b0 || psel !== 1'b1 || done !== '0) stable = 1'b0;
    end
    n_tests++; if (stable !== 1'b1) begin n_fail++; $display("FAIL read_stall.stable_c1_c5 got %b want 1", stable); end
    tick();
    pop_exp(e);
    n_tests++; if (done !== e.done) begin n_fail++; $display("FAIL read_stall.done_c6 got %b want %b", done, e.done); end
    n_tests++; if (rsp_rdata !== 32'h5A5A_0001) begin n_fail++; $display("FAIL read_stall.rdata got %h want 5a5a0001", rsp_rdata); end
    n_tests++; if (rsp_err !== e.err) begin n_fail++; $display("FAIL read_stall.err got %b want %b", rsp_err, e.err); end
    req[1] = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    exp_t e;
    logic [NR-1:0] od;
    logic [DW-1:0] ord;
    logic oe;
    int lat;
    stall_n = 1000; rd_key = 32'h7777_0000;
    issue(0, 1'b0, 32'h400, '0);
    exp_tmo++;
    await_done(od, ord, oe, lat);
    pop_exp(e);
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL timeout.latency got %0d want %0d", lat, e.lat); end
    n_tests++; if ({od, oe, ord} !== {e.done, e.err, e.rdata}) begin n_fail++; $display("FAIL timeout.rsp got %b/%b/%h want %b/%b/%h", od, oe, ord, e.done, e.err, e.rdata); end
    n_tests++; if (timeout_cnt !== 8'(exp_tmo)) begin n_fail++; $display("FAIL timeout.cnt got %0d want %0d", timeout_cnt, exp_tmo); end
    req[0] = 1'b0;
    tick();
    stall_n = 1;
    issue(0, 1'b0, 32'h404, '0);
    await_done(od, ord, oe, lat);
    pop_exp(e);
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL timeout.recover_latency got %0d want %0d", lat, e.lat); end
    n_tests++; if ({od, oe, ord} !== {e.done, e.err, e.rdata}) begin n_fail++; $display("FAIL timeout.recover_rsp got %b/%b/%h want %b/%b/%h", od, oe, ord, e.done, e.err, e.rdata); end
    n_tests++; if (timeout_cnt !== 8'(exp_tmo)) begin n_fail++; $display("FAIL timeout.recover_cnt got %0d want %0d", timeout_cnt, exp_tmo); end
    req[0] = 1'b0;
    tick();
  endtask

  task automatic test_slverr();
    exp_t e;
    logic [NR-1:0] od;
    logic [DW-1:0] ord;
    logic oe;
    int lat;
    stall_n = 0; slv_err_en = 1'b1;
    issue(2, 1'b1, 32'h500, 32'hCAFE_F00D);
    await_done(od, ord, oe, lat);
    pop_exp(e);
    n_tests++; if (lat !== e.lat) begin n_fail++; $display("FAIL slverr.latency got %0d want %0d", lat, e.lat); end
    n_tests++; if ({od, oe, ord} !== {e.done, e.err, e.rdata}) begin n_fail++; $display("FAIL slverr.rsp got %b/%b/%h want %b/%b/%h", od, oe, ord, e.done, e.err, e.rdata); end
    n_tests++; if (timeout_cnt !== 8'(exp_tmo)) begin n_fail++; $display("FAIL slverr.cnt got %0d want %0d", timeout_cnt, exp_tmo); end
    slv_err_en = 1'b0;
    req[2] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [NR-1:0] od;
    logic [DW-1:0] ord;
    logic oe;
    int lat, pulses;
    stall_n = 1000; rd_key = 32'h3C3C_0000;
    issue(1, 1'b0, 32'h600, '0);
    tick(); tick(); tick();
    n_tests++; if ({psel, penable} !== 2'b11) begin n_fail++; $display("FAIL reset_mid.in_access got %b want 11", {psel, penable}); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if ({psel, penable} !== 2'b00) begin n_fail++; $display("FAIL reset_mid.async_clear got %b want 00", {psel, penable}); end
    sb_q.delete();
    req = '0;
    exp_tmo = 0;
    pulses = 0;
    tick(); if (done != '0) pulses++;
    tick(); if (done != '0) pulses++;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); if (done != '0) pulses++; end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL reset_mid.no_done got %0d pulses want 0", pulses); end
    n_tests++; if (timeout_cnt !== 8'(exp_tmo)) begin n_fail++; $display("FAIL reset_mid.cnt got %0d want %0d", timeout_cnt, exp_tmo); end
    stall_n = 0;
    issue(2, 1'b0, 32'h700, '0);
    await_done(od, ord, oe, lat);
    pop_exp(e);
    n_tests++; if ({lat, od, oe, ord} !== {e.lat, e.done, e.err, e.rdata}) begin n_fail++; $display("FAIL reset_mid.req2 got %0d/%b/%b/%h want %0d/%b/%b/%h", lat, od, oe, ord, e.lat, e.done, e.err, e.rdata); end
    req[2] = 1'b0;
    tick();
    issue(0, 1'b1, 32'h800, 32'h0000_00A0);
    issue(2, 1'b0, 32'h808, '0);
    for (int k = 0; k < 2; k++) begin
      await_done(od, ord, oe, lat);
      pop_exp(e);
      n_tests++; if ({od, oe, ord} !== {e.done, e.err, e.rdata}) begin n_fail++; $display("FAIL reset_mid.req101 k=%0d got %b/%b/%h want %b/%b/%h", k, od, oe, ord, e.done, e.err, e.rdata); end
      req = req & ~od;
    end
    req = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_read_stall();
    test_timeout();
    test_slverr();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit got no finish want finish");
    $fatal(1);
  end

endmodule
